serial_add_sub: RTL and testbench

Bit-serial adder/subtractor for the arithmetic datapath. It consumes the two's-complement operands one bit per clock, LSB first, through a single full-adder cell built from two-input NAND gates. It returns the WIDTH-bit result, carry and signed-overflow flags behind a start/done handshake. The block trades WIDTH cycles of latency for one adder cell instead of WIDTH cells.

---
 rtl/serial_add_sub.sv | 116 +++++++++++
 tb/tb_serial_add_sub.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one NAND-gate full-adder cell
// walks the operands LSB first, then presents result/carry/overflow for one cycle.
module serial_add_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic [CntW-1:0]    r_cnt;
    logic               r_c;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_n1, w_n2, w_n3, w_x, w_n4, w_n5, w_n6;

    // Nine-NAND full adder: w_x = a^b, sum = w_x^c, carry = majority(a, b, c).
    assign w_n1 = ~(r_a_sh[0] & r_b_sh[0]);
    assign w_n2 = ~(r_a_sh[0] & w_n1);
    assign w_n3 = ~(r_b_sh[0] & w_n1);
    assign w_x  = ~(w_n2 & w_n3);
    assign w_n4 = ~(w_x & r_c);
    assign w_n5 = ~(w_x & w_n4);
    assign w_n6 = ~(r_c & w_n4);
    assign w_s    = ~(w_n5 & w_n6);
    assign w_cout = ~(w_n1 & w_n4);

    assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
    assign w_accept   = (r_state == StIdle) && i_start;
    assign w_last     = (r_cnt == CntW'(WIDTH - 1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_d = StRun;
            StRun:   if (w_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            r_a_sh   <= i_data_a;
            r_b_sh   <= i_sub ? ~i_data_b : i_data_b;
            r_c      <= i_sub;
            r_cnt    <= '0;
            r_sum_sh <= '0;
        end else if (r_state == StRun) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_next;
            r_c      <= w_cout;
            r_cnt    <= r_cnt + CntW'(1);
            if (w_last) begin
                // r_c is still the carry into the MSB on this step.
                r_result    <= w_sum_next;
                r_carry_out <= w_cout;
                r_overflow  <= r_c ^ w_cout;
            end
        end
    end

    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add_sub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] da = '0;
    logic [W-1:0] db = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;

    int           checks = 0;
    int           errors = 0;
    logic [9:0]   exp_q[$];
    logic [9:0]   hold = '0;
    logic         prev_done = 1'b0;

    serial_add_sub #(.WIDTH(W)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_start     (start),
        .i_sub       (sub),
        .i_data_a    (da),
        .i_data_b    (db),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_carry_out (carry),
        .o_overflow  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {carry, overflow, result}.
    function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
        int ua, ub, sa, sb, sr;
        logic [7:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = s ? sa - sb : sa + sb;
        r  = s ? a - b : a + b;
        c  = s ? (ua >= ub) : (ua + ub > 255);
        v  = (sr > 127) || (sr < -128);
        return {c, v, r};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold      <= '0;
            prev_done <= 1'b0;
        end else begin
            if (done) begin
                check("done_one_cycle", prev_done, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("result", result, e[7:0]);
                    check("carry_out", carry, e[9]);
                    check("overflow", ovf, e[8]);
                    hold <= e;
                end
            end else begin
                check("outputs_hold", {carry, ovf, result}, hold);
            end
            prev_done <= done;
        end
    end

    // Issue one op; lat = edges after accept until done, bcy = cycles busy was seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [9:0] e, input int pulse_k,
                          output int lat, output int bcy);
        @(negedge clk);
        start = 1'b1;
        da    = a;
        db    = b;
        sub   = s;
        exp_q.push_back(e);
        lat = -1;
        bcy = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            start = (k == pulse_k);
            if (k == pulse_k) begin
                sub = 1'b1;
                da  = 8'hAA;
                db  = 8'h55;
            end else if (k == 0) begin
                da  = 8'($urandom);
                db  = 8'($urandom);
                sub = 1'($urandom);
            end
            if (busy) bcy++;
            if (done) lat = k;
            if (!busy) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, bcy;
        int times[$];

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(8'h3C, 8'h0F, 1'b0, {1'b0, 1'b0, 8'h4B}, -1, lat, bcy);
        check("latency_add", lat, 8);
        check("busy_cycles", bcy, 9);
        run_op(8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 8'h00}, -1, lat, bcy);
        check("latency_ff01", lat, 8);
        run_op(8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80}, -1, lat, bcy);
        run_op(8'h05, 8'h07, 1'b1, {1'b0, 1'b0, 8'hFE}, -1, lat, bcy);
        run_op(8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F}, -1, lat, bcy);
        check("latency_sub", lat, 8);

        run_op(8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30}, 3, lat, bcy);
        check("latency_ignored_start", lat, 8);
        check("busy_ignored_start", bcy, 9);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] a, b;
            logic s;
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            run_op(a, b, s, ref_op(a, b, s), -1, lat, bcy);
            check("latency_random", lat, 8);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // start held high for 30 edges: accepts at edges 0, 10, 20.
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        da    = 8'h3C;
        db    = 8'h0F;
        repeat (3) exp_q.push_back({1'b0, 1'b0, 8'h4B});
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 29) start = 1'b0;
            if (done) times.push_back(k);
        end
        check("held_done_count", times.size(), 3);
        if (times.size() == 3) begin
            check("held_first_done", times[0], 8);
            check("held_period_1", times[1] - times[0], 10);
            check("held_period_2", times[2] - times[1], 10);
        end

        // Abort mid-run: reset lands between bit steps 3 and 4.
        @(negedge clk);
        start = 1'b1;
        da    = 8'h3C;
        db    = 8'h0F;
        sub   = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h4B});
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_result", result, 0);
        check("async_carry", carry, 0);
        check("async_ovf", ovf, 0);
        repeat (3) begin
            @(negedge clk);
            check("reset_no_done", done, 0);
            check("reset_no_busy", busy, 0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02}, -1, lat, bcy);
        check("latency_after_reset", lat, 8);
        check("queue_drained", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
